parity_checker_1: RTL



---
 rtl/parity_checker_1.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/parity_checker_1.sv
// Bit-serial receive-side parity checker.
// Captures a data word, its received parity bit and the even/odd convention,
// then consumes the word one bit per cycle, LSB first. Afterwards it reports
// pass/fail and keeps a saturating count of failed checks.
//
// state  | meaning
// -------+-------------------------------------------------------------
// WAIT   | idle, a start here captures inputs and begins a check
// SCAN   | fold one data bit per cycle into the running parity
// CHECK  | compare running parity with received bit, update err count
// FINISH | one-cycle done pulse, results already valid

module parity_checker_1 #(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     parity_in,
  input  logic                     odd_mode,
  input  logic                     clear_err,
  output logic                     busy,
  output logic                     done,
  output logic                     parity_ok,
  output logic                     parity_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  localparam logic [1:0] S_WAIT   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [DATA_WIDTH-1:0]    shift_q, shift_d;
  logic                     par_q, par_d;
  logic                     odd_q, odd_d;
  logic                     ones_q, ones_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     ok_q, ok_d;
  logic                     perr_q, perr_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic                     chk_err;

  // Running parity of the data combined with the received bit; for the odd
  // convention a correct word makes this 1, so odd_q folds that back to 0.
  assign chk_err = ones_q ^ par_q ^ odd_q;

  // Next-state and datapath update for the scan sequence.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    odd_d   = odd_q;
    ones_d  = ones_q;
    idx_d   = idx_q;
    ok_d    = ok_q;
    perr_d  = perr_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_WAIT: begin
        if (start) begin
          shift_d = data_in;
          par_d   = parity_in;
          odd_d   = odd_mode;
          ones_d  = 1'b0;
          idx_d   = '0;
          ok_d    = 1'b0;
          perr_d  = 1'b0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        ones_d  = ones_q ^ shift_q[0];
        shift_d = shift_q >> 1;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        perr_d = chk_err;
        ok_d   = ~chk_err;
        if (chk_err && (cnt_q != '1)) begin
          cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
        end
        state_d = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_WAIT;
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase

    // Clear has priority over a same-cycle increment.
    if (clear_err) begin
      cnt_d = '0;
    end

    busy_d = (state_d != S_WAIT);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT;
      shift_q <= '0;
      par_q   <= 1'b0;
      odd_q   <= 1'b0;
      ones_q  <= 1'b0;
      idx_q   <= '0;
      ok_q    <= 1'b0;
      perr_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      odd_q   <= odd_d;
      ones_q  <= ones_d;
      idx_q   <= idx_d;
      ok_q    <= ok_d;
      perr_q  <= perr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign done       = (state_q == S_FINISH);
  assign parity_ok  = ok_q;
  assign parity_err = perr_q;
  assign err_count  = cnt_q;

endmodule
